pc_ras: RTL and testbench
=========================

Name: pc_ras

Overview:
- Program-counter unit for the DLX fetch stage.
- Generalised successor of the basic PC register:
  - parametrised address width, reset vector and increment;
  - wider command set: sequential, relative, absolute, call, return, hold;
  - circular return-address stack (RAS) so calls and returns resolve in fetch.
- Drives the instruction-memory address; the decode/branch unit issues commands.

Parameters:
- WIDTH, 32, address/PC width in bits.
- RAS_DEPTH, 8, return-address stack entries; power of two, at least 2.
- RESET_VECTOR, 0, PC value loaded at reset.
- INC, 4, sequential increment in bytes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- IF  input  1  fetch enable; PC and RAS update only when 1.
- pc_cmd  input  3  command code; see Behaviour.
- pc_v  input  WIDTH  offset for relative commands, target for absolute commands.
- i_address  output  WIDTH  current PC, combinational copy of the PC register.
- ras_count  output  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_empty  output  1  ras_count == 0.
- ras_full  output  1  ras_count == RAS_DEPTH.
- ras_overflow  output  1  one-cycle pulse: a push overwrote the oldest entry.
- ras_underflow  output  1  one-cycle pulse: return issued with an empty RAS.
- pc_misalign  output  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset (reset=1 at clock edge, regardless of IF or in-flight command):
  - PC = RESET_VECTOR; ras_count = 0; top pointer = 0;
  - ras_overflow, ras_underflow, pc_misalign = 0;
  - RAS contents are don't-care.
- i_address = PC with zero latency; a new PC appears the cycle after the command.
- IF=0: PC, RAS and count hold; all pulse outputs are 0 next cycle; pc_cmd is ignored.
- IF=1, per pc_cmd:
  - 000 SEQ: PC <= PC+INC.
  - 001 REL: PC <= PC+pc_v.
  - 010 ABS: PC <= pc_v.
  - 011 CALL_REL: push PC+INC; PC <= PC+pc_v.
  - 100 CALL_ABS: push PC+INC; PC <= pc_v.
  - 101 RET, RAS not empty: PC <= top entry; pop.
  - 101 RET, RAS empty: PC <= PC+INC; ras_underflow=1 next cycle; count stays 0.
  - 110 HOLD: PC unchanged (fetch replay).
  - 111 reserved: behaves as SEQ.
- Arithmetic: all adds are modulo 2^WIDTH and wrap silently; pc_v is treated as two's complement for REL.
- RAS structure: circular buffer with a top pointer.
  - Push writes at top+1 (mod RAS_DEPTH), then advances top.
  - Pop reads at top, then decrements top.
- Push when full:
  - oldest entry is overwritten; count saturates at RAS_DEPTH;
  - ras_overflow=1 next cycle.
  - After RAS_DEPTH+k pushes, the RAS_DEPTH most recent addresses pop in LIFO order.
- Pulse outputs are registered, set for exactly one cycle per event, and are 0 otherwise.
- Only one command per cycle, so push and pop never occur together.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - When IF=1 and the computed next PC has bits[1:0] != 0, the PC holds, the RAS is not modified, and pc_misalign=1 next cycle.
  - RET with a misaligned popped value also holds and leaves the entry on the stack.
- Not defined: pc_misalign is tied to 0 and every target is loaded unchecked.

Test Plan:
- Reset, then 3 cycles IF=1, cmd=SEQ -> i_address 0x0, 0x4, 0x8, 0xC; ras_empty=1.
- PC=0x100: REL pc_v=0xFFFFFFF0, then ABS pc_v=0xFFFFFFFC, then SEQ -> 0xF0, 0xFFFFFFFC, 0x0 (wrap).
- PC=0x10: CALL_ABS 0x200, CALL_REL 0x40, RET, RET -> 0x200, 0x240, 0x204, 0x14; count 1, 2, 1, 0.
- RAS_DEPTH=8: 9 CALL_ABS from distinct PCs -> ras_overflow pulses on the 9th; 8 RETs return the last 8 return addresses LIFO; the 9th RET pulses ras_underflow and PC advances by 4.
- IF=0 with cmd=ABS 0x400 for 2 cycles, then reset asserted mid-CALL -> PC unchanged while IF=0; after reset PC=RESET_VECTOR and count=0.
- PC_ALIGN_CHECK_EN defined, ABS pc_v=0x102 -> PC holds, pc_misalign pulses once; the same stimulus without the macro -> PC=0x102, pc_misalign=0.

Source files
------------

// File: rtl/pc_ras.sv
// pc_ras: DLX fetch-stage program counter with a circular return-address stack.
// Commands: sequential, relative, absolute, call (rel/abs), return, hold.
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, a misaligned next PC
// holds the PC, leaves the RAS untouched and pulses pc_misalign. When undefined,
// pc_misalign is tied to 0 and targets load unchecked.
module pc_ras #(
  parameter int unsigned             WIDTH        = 32,
  parameter int unsigned             RAS_DEPTH    = 8,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = '0,
  parameter int unsigned             INC          = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           IF,
  input  logic [2:0]                     pc_cmd,
  input  logic [WIDTH-1:0]               pc_v,
  output logic [WIDTH-1:0]               i_address,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_overflow,
  output logic                           ras_underflow,
  output logic                           pc_misalign
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    CmdSeq     = 3'b000,
    CmdRel     = 3'b001,
    CmdAbs     = 3'b010,
    CmdCallRel = 3'b011,
    CmdCallAbs = 3'b100,
    CmdRet     = 3'b101,
    CmdHold    = 3'b110,
    CmdRsvd    = 3'b111
  } pc_cmd_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PtrW-1:0]  top_q, top_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] next_pc;
  logic [PtrW-1:0]  top_inc;
  logic             stack_empty;
  logic             stack_full;
  logic             push;
  logic             pop;
  logic             ret_empty;
  logic             misaligned;

  assign pc_inc      = pc_q + WIDTH'(INC);
  assign pc_rel      = pc_q + pc_v;
  assign top_inc     = top_q + PtrW'(1);
  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CntW'(RAS_DEPTH));

  // Decode the command into a candidate next PC and a stack action.
  always_comb begin
    next_pc   = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    ret_empty = 1'b0;
    unique case (pc_cmd_e'(pc_cmd))
      CmdSeq:     next_pc = pc_inc;
      CmdRel:     next_pc = pc_rel;
      CmdAbs:     next_pc = pc_v;
      CmdCallRel: begin
        next_pc = pc_rel;
        push    = 1'b1;
      end
      CmdCallAbs: begin
        next_pc = pc_v;
        push    = 1'b1;
      end
      CmdRet: begin
        if (stack_empty) begin
          next_pc   = pc_inc;
          ret_empty = 1'b1;
        end else begin
          next_pc = ras_q[top_q];
          pop     = 1'b1;
        end
      end
      CmdHold:    next_pc = pc_q;
      CmdRsvd:    next_pc = pc_inc;
      default:    next_pc = pc_inc;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = |next_pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Next-state for PC, stack pointer, occupancy and event pulses.
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (IF && !misaligned) begin
      pc_d  = next_pc;
      udf_d = ret_empty;
      if (push) begin
        top_d   = top_inc;
        // A full stack overwrites its oldest slot, so occupancy saturates.
        count_d = stack_full ? count_q : count_q + CntW'(1);
        ovf_d   = stack_full;
      end else if (pop) begin
        top_d   = top_q - PtrW'(1);
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Architectural state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Stack storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (!reset && IF && !misaligned && push) begin
      ras_q[top_inc] <= pc_inc;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;

  // Misalignment pulse, one cycle per rejected update.
  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= IF && misaligned;
    end
  end

  assign pc_misalign = mis_q;
`else
  assign pc_misalign = 1'b0;
`endif

  assign i_address     = pc_q;
  assign ras_count     = count_q;
  assign ras_empty     = stack_empty;
  assign ras_full      = stack_full;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = udf_q;

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: table-driven directed vectors plus hand-written RAS overflow,
// underflow and alignment sequences for pc_ras (WIDTH=32, RAS_DEPTH=8, INC=4).
module tb_pc_ras;

  localparam int unsigned W = 32;
  localparam int unsigned D = 8;

  localparam logic [2:0] SEQ  = 3'b000;
  localparam logic [2:0] REL  = 3'b001;
  localparam logic [2:0] ABS  = 3'b010;
  localparam logic [2:0] CREL = 3'b011;
  localparam logic [2:0] CABS = 3'b100;
  localparam logic [2:0] RET  = 3'b101;
  localparam logic [2:0] HOLD = 3'b110;
  localparam logic [2:0] RSVD = 3'b111;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_en;
  logic [2:0]   cmd;
  logic [W-1:0] pc_v;
  logic [W-1:0] i_address;
  logic [3:0]   ras_count;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_overflow;
  logic         ras_underflow;
  logic         pc_misalign;

  int checks = 0;
  int errors = 0;

  pc_ras #(
    .WIDTH       (W),
    .RAS_DEPTH   (D),
    .RESET_VECTOR(32'h0),
    .INC         (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .IF           (if_en),
    .pc_cmd       (cmd),
    .pc_v         (pc_v),
    .i_address    (i_address),
    .ras_count    (ras_count),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow),
    .pc_misalign  (pc_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic [2:0]   cmd;
    logic [W-1:0] v;
    logic [W-1:0] exp_addr;
    logic [3:0]   exp_cnt;
    logic         exp_ovf;
    logic         exp_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic [2:0] c,
                              input logic [W-1:0] v, input logic [W-1:0] a,
                              input logic [3:0] n, input logic o, input logic u);
    vec_t r;
    r.rst = rst; r.en = en; r.cmd = c; r.v = v;
    r.exp_addr = a; r.exp_cnt = n; r.exp_ovf = o; r.exp_udf = u;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic [2:0] c, input logic [W-1:0] v);
    reset = r; if_en = f; cmd = c; pc_v = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] a, input logic [3:0] n,
                           input logic o, input logic u, input logic m);
    chk({tag, ".addr"}, i_address, a);
    chk({tag, ".count"}, {28'h0, ras_count}, {28'h0, n});
    chk({tag, ".empty"}, {31'h0, ras_empty}, {31'h0, (n == 4'd0)});
    chk({tag, ".full"}, {31'h0, ras_full}, {31'h0, (n == 4'd8)});
    chk({tag, ".ovf"}, {31'h0, ras_overflow}, {31'h0, o});
    chk({tag, ".udf"}, {31'h0, ras_underflow}, {31'h0, u});
    chk({tag, ".mis"}, {31'h0, pc_misalign}, {31'h0, m});
  endtask

  logic [W-1:0] ret_addr [9];
  logic [W-1:0] prev_pc;
  logic [W-1:0] tgt;

  initial begin
    reset = 1'b1; if_en = 1'b0; cmd = SEQ; pc_v = '0;

    // Reset, sequential fetch, REL/ABS wrap, calls/returns, hold, reserved.
    vecs.push_back(mk(1, 1, SEQ,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  32'h0,        32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  32'h0,        32'h8,        0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  32'h0,        32'hC,        0, 0, 0));
    vecs.push_back(mk(0, 1, ABS,  32'h100,      32'h100,      0, 0, 0));
    vecs.push_back(mk(0, 1, REL,  32'hFFFFFFF0, 32'hF0,       0, 0, 0));
    vecs.push_back(mk(0, 1, ABS,  32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, ABS,  32'h10,       32'h10,       0, 0, 0));
    vecs.push_back(mk(0, 1, CABS, 32'h200,      32'h200,      1, 0, 0));
    vecs.push_back(mk(0, 1, CREL, 32'h40,       32'h240,      2, 0, 0));
    vecs.push_back(mk(0, 1, RET,  32'h0,        32'h204,      1, 0, 0));
    vecs.push_back(mk(0, 1, RET,  32'h0,        32'h14,       0, 0, 0));
    vecs.push_back(mk(0, 1, HOLD, 32'h0,        32'h14,       0, 0, 0));
    vecs.push_back(mk(0, 1, RSVD, 32'h0,        32'h18,       0, 0, 0));
    vecs.push_back(mk(0, 0, ABS,  32'h400,      32'h18,       0, 0, 0));
    vecs.push_back(mk(0, 0, ABS,  32'h400,      32'h18,       0, 0, 0));
    vecs.push_back(mk(0, 1, CABS, 32'h300,      32'h300,      1, 0, 0));
    vecs.push_back(mk(1, 1, CABS, 32'h500,      32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, RET,  32'h0,        32'h4,        0, 0, 1));
    vecs.push_back(mk(0, 0, RET,  32'h0,        32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 1, RET,  32'h0,        32'h8,        0, 0, 1));
    vecs.push_back(mk(0, 1, SEQ,  32'h0,        32'hC,        0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].cmd, vecs[i].v);
      check_all($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_cnt,
                vecs[i].exp_ovf, vecs[i].exp_udf, 1'b0);
    end

    // Nine calls from distinct PCs: the ninth overwrites the oldest entry.
    step(0, 1, ABS, 32'h800);
    check_all("ovf.start", 32'h800, 0, 0, 0, 0);
    prev_pc = 32'h800;
    for (int i = 0; i < 9; i++) begin
      tgt = 32'h1000 * (i + 1);
      ret_addr[i] = prev_pc + 32'h4;
      step(0, 1, CABS, tgt);
      check_all($sformatf("call%0d", i), tgt, (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 0, 0);
      prev_pc = tgt;
    end

    // Eight returns give back the eight newest return addresses, newest first.
    for (int j = 0; j < 8; j++) begin
      step(0, 1, RET, 32'h0);
      check_all($sformatf("ret%0d", j), ret_addr[8 - j], 4'(7 - j), 0, 0, 0);
    end

    // Oldest address was lost, so the ninth return underflows and falls through.
    step(0, 1, RET, 32'h0);
    check_all("ret8", ret_addr[1] + 32'h4, 0, 0, 1, 0);

    // Misaligned absolute target.
    step(0, 1, ABS, 32'h0);
    check_all("align.base", 32'h0, 0, 0, 0, 0);
    step(0, 1, ABS, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
    check_all("align.abs", 32'h0, 0, 0, 0, 1);
    step(0, 1, HOLD, 32'h0);
    check_all("align.after", 32'h0, 0, 0, 0, 0);
`else
    check_all("align.abs", 32'h102, 0, 0, 0, 0);
    step(0, 1, HOLD, 32'h0);
    check_all("align.after", 32'h102, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
